stage_envelope_generator: RTL and testbench
===========================================

Name: stage_envelope_generator

Overview:
- Per-operator ADSR envelope stage directly downstream of the phase accumulator stage.
- Consumes the phase accumulator's phase, note-on and voice-operator outputs.
- Advances one operator's envelope state per clock from its stored state and config.
- Emits a 16-bit envelope level, with phase and voice-operator delayed to stay aligned, for the waveform/output stage.
- 2-clock pipeline, same time-multiplexed scheme as the phase accumulator: one operator slot per clock.

Parameters:
- NUM_OPERATORS, 256, voice-operator slots (32 voices x 8 operators); must equal `NUM_VOICE_OPERATORS.
- OP_ID_WIDTH, 8, log2(NUM_OPERATORS); width of `VOICE_OPERATOR_ID.
- LEVEL_MAX, 16'hFFFF, attack target level.

Ports:
- i_Clock  in  1  sole clock; all logic on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Phase  in  16  phase from phase accumulator.
- i_NoteOn  in  1  gate for this operator's voice.
- i_VoiceOperator  in  OP_ID_WIDTH  operator slot of current inputs.
- i_EnvConfigWriteEnable  in  4  bit3 attack rate, bit2 decay rate, bit1 sustain level, bit0 release rate.
- i_ConfigWriteAddr  in  OP_ID_WIDTH  operator addressed by config write.
- i_ConfigWriteData  in  16  config value.
- o_Phase  out  16  i_Phase delayed 2 clocks.
- o_Envelope  out  16  updated envelope level for o_VoiceOperator.
- o_NoteOn  out  1  i_NoteOn delayed 2 clocks.
- o_VoiceOperator  out  OP_ID_WIDTH  i_VoiceOperator delayed 2 clocks.

Behaviour:
- Per-operator storage:
  - state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; 3 bits.
  - level: 16 bits, unsigned.
  - prev_note_on: 1 bit.
  - valid: 1 bit, one flop per operator.
- Config RAMs (attack, decay, sustain, release; 16 bits each) are not reset.
  - A write takes effect from the next clock.
  - A same-cycle read of the same address returns the old value.
- Reset:
  - Clears all valid bits and all pipeline registers.
  - o_Phase, o_Envelope, o_NoteOn and o_VoiceOperator read 0 on the first edge after reset is asserted.
  - Reset asserted mid-operation discards in-flight operators. No state write-back occurs while i_Reset=1.
  - An operator with valid=0 reads as IDLE, level 0, prev_note_on 0.
- Clock 1: register inputs, the operator's stored state and its four config words.
- Clock 2: compute next state/level (below), write it back to storage with valid=1, and register the outputs.
- Total latency is 2 clocks, fully pipelined, one operator per clock.
- Next-state rules (g = NoteOn, p = prev_note_on); stored prev_note_on <= g:
  - g & !p: enter ATTACK, level = sat(level + attack). Attack starts from the current level, with no reset to 0.
  - ATTACK & g: level + attack (17-bit). If >= LEVEL_MAX: level = LEVEL_MAX, go to DECAY.
  - DECAY & g: level - decay (17-bit signed). If <= sustain: level = sustain, go to SUSTAIN.
  - SUSTAIN & g: level = current sustain config, which tracks config changes.
  - !g & state != IDLE: go to RELEASE and apply level - release in the same clock. If <= 0: level = 0, go to IDLE.
  - IDLE & !g: level stays 0.
  - A rate of 0 holds the level in that phase indefinitely. With attack=0, the operator never leaves ATTACK.
- Hazard handling: if the clock-1 operator equals the clock-2 operator (back-to-back same ID), the clock-1 read uses the clock-2 computed state/level/prev_note_on, not stale storage.
- o_Envelope equals the written-back level.

Decomposition:
- Shared package synth_pkg:
  - env_state_t enum.
  - LEVEL_MAX.
  - Config-enable bit indices.
  - Reuse the existing `VOICE_OPERATOR_ID / `NUM_VOICE_OPERATORS macros.
- Sub-module envelope_step: combinational next-state/level function of state, level, g, p and 4 configs. It is unit-tested on its own.

Test Plan:
- Reset: hold i_Reset 2 clocks, then run an operator with g=0 -> o_Envelope=0 and all outputs 0; after reset, every operator reads IDLE.
- Attack: op 5, attack=0x4000, note on, revisited every 256 clocks -> levels 0x4000, 0x8000, 0xC000, then 0xFFFF with state DECAY on the 4th visit.
- Decay/sustain: decay=0x2000, sustain=0xA000 after attack -> 0xDFFF, 0xBFFF, then 0xA000 held; changing sustain to 0x9000 gives 0x9000 on the next visit.
- Release: g falls in DECAY at 0xDFFF with release=0x8000 -> 0x5FFF, then 0 and IDLE; retrigger gives attack from 0.
- Back-to-back same ID: present op 7 two consecutive clocks with g=1, attack=0x100 -> o_Envelope 0x0100, then 0x0200, proving the bypass.
- Alignment: random phases/IDs -> o_Phase, o_NoteOn and o_VoiceOperator equal their inputs from 2 clocks earlier; config write to op 3 in the same cycle op 3 is read uses the old value.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice pipeline stages.
// Voice-operator slot macros, envelope state encoding and config-enable bit indices.
`ifndef SYNTH_VOICE_DEFS
`define SYNTH_VOICE_DEFS
`define NUM_VOICE_OPERATORS 256
`define VOICE_OPERATOR_ID logic [7:0]
`endif

package synth_pkg;
    typedef `VOICE_OPERATOR_ID voice_op_t;

    localparam int          NUM_OPERATORS = `NUM_VOICE_OPERATORS;
    localparam int          OP_ID_WIDTH   = $bits(voice_op_t);
    localparam logic [15:0] LEVEL_MAX     = 16'hFFFF;

    localparam int CFG_RELEASE = 0;
    localparam int CFG_SUSTAIN = 1;
    localparam int CFG_DECAY   = 2;
    localparam int CFG_ATTACK  = 3;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;
endpackage

// File: rtl/envelope_step.sv
// Combinational ADSR step: next state and level from current state, gate edge and rates.
module envelope_step
    import synth_pkg::*;
(
    input  env_state_t  i_State,
    input  logic [15:0] i_Level,
    input  logic        i_Gate,
    input  logic        i_PrevGate,
    input  logic [15:0] i_Attack,
    input  logic [15:0] i_Decay,
    input  logic [15:0] i_Sustain,
    input  logic [15:0] i_Release,
    output env_state_t  o_State,
    output logic [15:0] o_Level
);
    logic [16:0]        w_AttackSum;
    logic signed [16:0] w_DecayDiff;
    logic signed [16:0] w_ReleaseDiff;
    logic [15:0]        w_AttackSat;

    assign w_AttackSum   = {1'b0, i_Level} + {1'b0, i_Attack};
    assign w_DecayDiff   = $signed({1'b0, i_Level}) - $signed({1'b0, i_Decay});
    assign w_ReleaseDiff = $signed({1'b0, i_Level}) - $signed({1'b0, i_Release});
    assign w_AttackSat   = (w_AttackSum >= {1'b0, LEVEL_MAX}) ? LEVEL_MAX : w_AttackSum[15:0];

    always_comb begin
        o_State = i_State;
        o_Level = i_Level;
        unique case (1'b1)
            i_Gate && !i_PrevGate: begin
                o_State = ENV_ATTACK;
                o_Level = w_AttackSat;
            end
            i_Gate && i_PrevGate: begin
                case (i_State)
                    ENV_ATTACK: begin
                        o_Level = w_AttackSat;
                        if (w_AttackSum >= {1'b0, LEVEL_MAX})
                            o_State = ENV_DECAY;
                    end
                    ENV_DECAY: begin
                        if (w_DecayDiff <= $signed({1'b0, i_Sustain})) begin
                            o_State = ENV_SUSTAIN;
                            o_Level = i_Sustain;
                        end else begin
                            o_Level = w_DecayDiff[15:0];
                        end
                    end
                    ENV_SUSTAIN: o_Level = i_Sustain;
                    default: ;
                endcase
            end
            !i_Gate && (i_State != ENV_IDLE): begin
                // Release is applied in the same clock the gate drops
                if (w_ReleaseDiff <= 17'sd0) begin
                    o_State = ENV_IDLE;
                    o_Level = 16'h0000;
                end else begin
                    o_State = ENV_RELEASE;
                    o_Level = w_ReleaseDiff[15:0];
                end
            end
            default: begin
                o_State = ENV_IDLE;
                o_Level = 16'h0000;
            end
        endcase
    end
endmodule

// File: rtl/stage_envelope_generator.sv
// Time-multiplexed per-operator ADSR envelope stage, 2-clock pipeline.
// Clock 1 reads operator state and config; clock 2 steps, writes back and registers outputs.
module stage_envelope_generator
    import synth_pkg::*;
#(
    parameter int NUM_OPERATORS = synth_pkg::NUM_OPERATORS,
    parameter int OP_ID_WIDTH   = synth_pkg::OP_ID_WIDTH
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [15:0]            i_Phase,
    input  logic                   i_NoteOn,
    input  logic [OP_ID_WIDTH-1:0] i_VoiceOperator,
    input  logic [3:0]             i_EnvConfigWriteEnable,
    input  logic [OP_ID_WIDTH-1:0] i_ConfigWriteAddr,
    input  logic [15:0]            i_ConfigWriteData,
    output logic [15:0]            o_Phase,
    output logic [15:0]            o_Envelope,
    output logic                   o_NoteOn,
    output logic [OP_ID_WIDTH-1:0] o_VoiceOperator
);
    env_state_t  r_StateMem   [NUM_OPERATORS];
    logic [15:0] r_LevelMem   [NUM_OPERATORS];
    logic [15:0] r_AttackMem  [NUM_OPERATORS];
    logic [15:0] r_DecayMem   [NUM_OPERATORS];
    logic [15:0] r_SustainMem [NUM_OPERATORS];
    logic [15:0] r_ReleaseMem [NUM_OPERATORS];
    logic [NUM_OPERATORS-1:0] r_PrevMem;
    logic [NUM_OPERATORS-1:0] r_ValidMem;

    logic                   r_S1Valid;
    logic [15:0]            r_S1Phase;
    logic                   r_S1NoteOn;
    logic [OP_ID_WIDTH-1:0] r_S1Op;
    env_state_t             r_S1State;
    logic [15:0]            r_S1Level;
    logic                   r_S1Prev;
    logic [15:0]            r_S1Attack;
    logic [15:0]            r_S1Decay;
    logic [15:0]            r_S1Sustain;
    logic [15:0]            r_S1Release;

    env_state_t  w_NextState;
    logic [15:0] w_NextLevel;
    logic        w_Bypass;
    logic        w_RdValid;
    env_state_t  w_RdState;
    logic [15:0] w_RdLevel;
    logic        w_RdPrev;

    envelope_step u_step (
        .i_State   (r_S1State),
        .i_Level   (r_S1Level),
        .i_Gate    (r_S1NoteOn),
        .i_PrevGate(r_S1Prev),
        .i_Attack  (r_S1Attack),
        .i_Decay   (r_S1Decay),
        .i_Sustain (r_S1Sustain),
        .i_Release (r_S1Release),
        .o_State   (w_NextState),
        .o_Level   (w_NextLevel)
    );

    // Same operator in both stages: forward the result still being written back
    assign w_Bypass  = r_S1Valid && (i_VoiceOperator == r_S1Op);
    assign w_RdValid = r_ValidMem[i_VoiceOperator];

    always_comb begin
        w_RdState = ENV_IDLE;
        w_RdLevel = 16'h0000;
        w_RdPrev  = 1'b0;
        if (w_Bypass) begin
            w_RdState = w_NextState;
            w_RdLevel = w_NextLevel;
            w_RdPrev  = r_S1NoteOn;
        end else if (w_RdValid) begin
            w_RdState = r_StateMem[i_VoiceOperator];
            w_RdLevel = r_LevelMem[i_VoiceOperator];
            w_RdPrev  = r_PrevMem[i_VoiceOperator];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_EnvConfigWriteEnable[CFG_ATTACK])
            r_AttackMem[i_ConfigWriteAddr] <= i_ConfigWriteData;
        if (i_EnvConfigWriteEnable[CFG_DECAY])
            r_DecayMem[i_ConfigWriteAddr] <= i_ConfigWriteData;
        if (i_EnvConfigWriteEnable[CFG_SUSTAIN])
            r_SustainMem[i_ConfigWriteAddr] <= i_ConfigWriteData;
        if (i_EnvConfigWriteEnable[CFG_RELEASE])
            r_ReleaseMem[i_ConfigWriteAddr] <= i_ConfigWriteData;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset && r_S1Valid) begin
            r_StateMem[r_S1Op] <= w_NextState;
            r_LevelMem[r_S1Op] <= w_NextLevel;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_ValidMem <= '0;
            r_PrevMem  <= '0;
        end else if (r_S1Valid) begin
            r_ValidMem[r_S1Op] <= 1'b1;
            r_PrevMem[r_S1Op]  <= r_S1NoteOn;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_S1Valid   <= 1'b0;
            r_S1Phase   <= '0;
            r_S1NoteOn  <= 1'b0;
            r_S1Op      <= '0;
            r_S1State   <= ENV_IDLE;
            r_S1Level   <= '0;
            r_S1Prev    <= 1'b0;
            r_S1Attack  <= '0;
            r_S1Decay   <= '0;
            r_S1Sustain <= '0;
            r_S1Release <= '0;
        end else begin
            r_S1Valid   <= 1'b1;
            r_S1Phase   <= i_Phase;
            r_S1NoteOn  <= i_NoteOn;
            r_S1Op      <= i_VoiceOperator;
            r_S1State   <= w_RdState;
            r_S1Level   <= w_RdLevel;
            r_S1Prev    <= w_RdPrev;
            r_S1Attack  <= r_AttackMem[i_VoiceOperator];
            r_S1Decay   <= r_DecayMem[i_VoiceOperator];
            r_S1Sustain <= r_SustainMem[i_VoiceOperator];
            r_S1Release <= r_ReleaseMem[i_VoiceOperator];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset || !r_S1Valid) begin
            o_Phase         <= '0;
            o_Envelope      <= '0;
            o_NoteOn        <= 1'b0;
            o_VoiceOperator <= '0;
        end else begin
            o_Phase         <= r_S1Phase;
            o_Envelope      <= w_NextLevel;
            o_NoteOn        <= r_S1NoteOn;
            o_VoiceOperator <= r_S1Op;
        end
    end
endmodule

// File: tb/tb_stage_envelope_generator.sv
// Scoreboard bench for stage_envelope_generator: directed ADSR vectors, bypass and alignment.
module tb_stage_envelope_generator;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ph;
    logic        g;
    logic [7:0]  op;
    logic [3:0]  we;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] o_ph;
    logic [15:0] o_env;
    logic        o_g;
    logic [7:0]  o_op;

    always #5 clk = ~clk;

    stage_envelope_generator dut (
        .i_Clock               (clk),
        .i_Reset               (rst),
        .i_Phase               (ph),
        .i_NoteOn              (g),
        .i_VoiceOperator       (op),
        .i_EnvConfigWriteEnable(we),
        .i_ConfigWriteAddr     (waddr),
        .i_ConfigWriteData     (wdata),
        .o_Phase               (o_ph),
        .o_Envelope            (o_env),
        .o_NoteOn              (o_g),
        .o_VoiceOperator       (o_op)
    );

    typedef struct {
        logic [15:0] ph;
        logic        g;
        logic [7:0]  op;
        logic [15:0] env;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.due != cyc) begin
                errors++;
                $display("FAIL %s: output slot missed at cycle %0d", e.name, cyc);
            end else begin
                chk({e.name, "_align"}, {7'd0, o_ph, o_g, o_op}, {7'd0, e.ph, e.g, e.op});
                chk({e.name, "_env"}, {16'd0, o_env}, {16'd0, e.env});
            end
        end
    end

    task automatic step(input logic [15:0] p, input logic gg, input logic [7:0] o,
                        input logic [15:0] env, input string name);
        exp_t e;
        ph = p;
        g  = gg;
        op = o;
        e.ph   = p;
        e.g    = gg;
        e.op   = o;
        e.env  = env;
        e.due  = cyc + 2;
        e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
        we = 4'd0;
    endtask

    task automatic cfg(input logic [3:0] en, input logic [7:0] a, input logic [15:0] d);
        we    = en;
        waddr = a;
        wdata = d;
        step(16'h1234, 1'b0, 8'd200, 16'h0000, "filler");
    endtask

    task automatic idle(input int n);
        ph = 16'h0;
        g  = 1'b0;
        op = 8'd201;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        ph    = 16'hBEEF;
        g     = 1'b1;
        op    = 8'd5;
        we    = 4'd0;
        waddr = 8'd0;
        wdata = 16'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_out", {7'd0, o_ph, o_g, o_op}, 32'd0);
            chk("reset_env", {16'd0, o_env}, 32'd0);
        end
        rst = 1'b0;
        step(16'h0011, 1'b0, 8'd5, 16'h0000, "post_reset_idle");

        for (int o = 5; o <= 6; o++) begin
            cfg(4'b1000, 8'(o), 16'h4000);
            cfg(4'b0100, 8'(o), 16'h2000);
            cfg(4'b0010, 8'(o), 16'hA000);
            cfg(4'b0001, 8'(o), 16'h8000);
        end
        cfg(4'b1000, 8'd7, 16'h0100);
        cfg(4'b1000, 8'd3, 16'h0010);
        cfg(4'b1111, 8'd9, 16'h0000);

        step(16'h0101, 1'b1, 8'd5, 16'h4000, "atk5_1");
        step(16'h0102, 1'b1, 8'd6, 16'h4000, "atk6_1");
        step(16'h0103, 1'b1, 8'd5, 16'h8000, "atk5_2");
        step(16'h0104, 1'b1, 8'd6, 16'h8000, "atk6_2");
        step(16'h0105, 1'b1, 8'd5, 16'hC000, "atk5_3");
        step(16'h0106, 1'b1, 8'd6, 16'hC000, "atk6_3");
        step(16'h0107, 1'b1, 8'd5, 16'hFFFF, "atk5_sat");
        step(16'h0108, 1'b1, 8'd6, 16'hFFFF, "atk6_sat");
        step(16'h0109, 1'b1, 8'd5, 16'hDFFF, "dec5_1");
        step(16'h010A, 1'b1, 8'd6, 16'hDFFF, "dec6_1");
        step(16'h010B, 1'b1, 8'd5, 16'hBFFF, "dec5_2");
        step(16'h010C, 1'b0, 8'd6, 16'h5FFF, "rel6_1");
        step(16'h010D, 1'b1, 8'd5, 16'hA000, "sus5_enter");
        step(16'h010E, 1'b0, 8'd6, 16'h0000, "rel6_idle");
        step(16'h010F, 1'b1, 8'd5, 16'hA000, "sus5_hold");
        step(16'h0110, 1'b0, 8'd6, 16'h0000, "idle6");
        cfg(4'b0010, 8'd5, 16'h9000);
        step(16'h0111, 1'b1, 8'd5, 16'h9000, "sus5_track");
        step(16'h0112, 1'b1, 8'd6, 16'h4000, "retrig6");

        step(16'h0201, 1'b1, 8'd7, 16'h0100, "b2b_1");
        step(16'h0202, 1'b1, 8'd7, 16'h0200, "b2b_2");
        step(16'h0203, 1'b1, 8'd7, 16'h0300, "b2b_3");

        we    = 4'b1000;
        waddr = 8'd3;
        wdata = 16'h0500;
        step(16'h0301, 1'b1, 8'd3, 16'h0010, "cfg_old");
        step(16'h0302, 1'b1, 8'd3, 16'h0510, "cfg_new");

        for (int i = 0; i < 20; i++) begin
            logic [15:0] rp;
            rp = 16'($urandom);
            if (i % 2 == 1)
                step(rp, 1'($urandom_range(0, 1)), 8'd9, 16'h0000, "rand_op9");
            else
                step(rp, 1'b0, 8'($urandom_range(16, 255)), 16'h0000, "rand_idle");
        end

        idle(3);
        rst = 1'b1;
        ph  = 16'hAAAA;
        g   = 1'b1;
        op  = 8'd5;
        @(posedge clk);
        #1;
        chk("midreset_out", {7'd0, o_ph, o_g, o_op}, 32'd0);
        chk("midreset_env", {16'd0, o_env}, 32'd0);
        rst = 1'b0;
        step(16'h0401, 1'b0, 8'd5, 16'h0000, "after_reset_idle5");
        step(16'h0402, 1'b1, 8'd5, 16'h4000, "after_reset_atk5");

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never arrived", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
